div_unit: RTL
=============

Name: div_unit

Overview:
- Iterative multi-cycle integer divider in the execute stage of cpu_v3.
- Consumes the same decoded operand buses as the ALU (src_a, src_b) and implements the RV32M DIV, DIVU, REM and REMU operations.
- Its result feeds the writeback result mux alongside the ALU result.
- Control stalls the pipeline while busy is high.

Parameters:
- WIDTH, 32, operand and result width in bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk    input   1      system clock, all state updates on rising edge
- rst    input   1      synchronous, active-high reset
- start  input   1      request a new division; sampled only while idle
- op     input   2      operation: DIV=0, DIVU=1, REM=2, REMU=3
- src_a  input   WIDTH  dividend
- src_b  input   WIDTH  divisor
- busy   output  1      high while an iterative division is in progress
- done   output  1      one-cycle pulse: res is valid from this cycle
- res    output  WIDTH  quotient (DIV/DIVU) or remainder (REM/REMU)

Behaviour:
- Reset:
  - On clk edge with rst=1: state=IDLE, busy=0, done=0, res=0, counter=0, internal registers=0.
  - rst overrides everything, including an in-flight division, which is abandoned with no done pulse.
- States:
  - IDLE: waits for start.
  - CALC: performs one restoring step per cycle.
- Start acceptance:
  - start is honoured only in IDLE; while busy=1 it is ignored.
  - When accepted, op, the operand signs and the operand magnitudes are latched. Later changes on the inputs have no effect.
- Signed ops (DIV, REM): magnitudes are the two's-complement absolute values.
  - Quotient sign = sign(a) XOR sign(b).
  - Remainder sign = sign(a).
- Unsigned ops (DIVU, REMU): operands are used as-is.
- Normal latency (start high in cycle 0):
  - Cycles 1..WIDTH: busy=1, done=0. Each cycle shifts the partial remainder left by one, subtracts the divisor magnitude, and if the result is non-negative keeps it and shifts in quotient bit 1, else shifts in 0.
  - Cycle WIDTH+1: state=IDLE, busy=0, done=1, res = sign-corrected quotient or remainder.
  - Sign correction is applied on the register write at the end of the last CALC cycle.
- Special cases, resolved in IDLE without entering CALC. For these, cycle 1 has busy=0, done=1 and res set:
  - Divide by zero (b=0): DIV/DIVU give all ones (0xFFFFFFFF); REM/REMU give src_a.
  - Signed overflow (DIV/REM, a=0x80000000, b=0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- Result hold: res stays stable after done until the next accepted start. When the next start is accepted, res may change only at that operation's done.
- done is a single-cycle pulse; it is never high while busy=1.
- Back-to-back operation: start may be asserted in the same cycle done=1. It is accepted, and busy rises the following cycle.
- Counter:
  - Loads 0 on accept and increments each CALC cycle.
  - CALC exits when counter == WIDTH-1 at the clock edge.
  - No wrap-around is possible.
- Undefined op values cannot occur (op is 2 bits, all four encodings defined).

Decomposition:
- Shared header div.mac.vh holds:
  - Op encodings DIV_DIV, DIV_DIVU, DIV_REM, DIV_REMU.
  - State encodings DIV_ST_IDLE, DIV_ST_CALC.
  - Included by div_unit and by the decoder.
- Sub-module div_step (combinational):
  - Takes the partial remainder, the dividend bit and the divisor magnitude.
  - Returns the next partial remainder and the quotient bit.
  - Keeps the FSM file focused on sequencing.

Test Plan:
- DIVU a=100, b=7: start in cycle 0 -> busy=1 in cycles 1..32; done=1 in cycle 33; res=14. REMU of the same operands -> res=2.
- DIV a=-7 (0xFFFFFFF9), b=2 -> res=0xFFFFFFFD (-3). REM of the same operands -> res=0xFFFFFFFF (-1).
- DIV a=0x80000000, b=0xFFFFFFFF -> done in cycle 1, res=0x80000000, busy never high. DIVU 5/0 -> cycle 1: res=0xFFFFFFFF. REMU 5/0 -> res=5.
- Start asserted with different operands during cycles 1..32 -> ignored: res is unchanged (14 from the first test) and the done timing is unchanged. Start held in the done cycle -> new op accepted, busy=1 the next cycle.
- rst=1 in cycle 10 of a DIVU -> next cycle busy=0, done=0, res=0. No done pulse appears afterwards; a fresh start then completes normally.
- Randomized: 1000 ops over all four encodings, including 0, 1, -1, 0x80000000 and 0x7FFFFFFF operands -> res matches the RV32M reference model.

Source files
------------

// File: rtl/div_unit_pkg.sv
// Shared encodings for the iterative RV32M divider: operation codes, FSM states
// and small op-classification helpers used by the divider and the decoder.
package div_unit_pkg;

   typedef enum logic [1:0] {
      DIV_DIV  = 2'd0,
      DIV_DIVU = 2'd1,
      DIV_REM  = 2'd2,
      DIV_REMU = 2'd3
   } op_e;

   typedef enum logic [0:0] {
      DIV_ST_IDLE = 1'b0,
      DIV_ST_CALC = 1'b1
   } state_e;

   function automatic logic is_rem_op(input op_e o);
      return (o == DIV_REM) || (o == DIV_REMU);
   endfunction

   function automatic logic is_signed_op(input op_e o);
      return (o == DIV_DIV) || (o == DIV_REM);
   endfunction

endpackage

// File: rtl/div_unit_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor if it fits.
module div_unit_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem_i,
   input  logic             bit_i,
   input  logic [WIDTH-1:0] div_i,
   output logic [WIDTH-1:0] rem_o,
   output logic             q_o
);

   logic [WIDTH:0] shifted_s;
   logic [WIDTH:0] diff_s;

   // The extra top bit keeps the shifted remainder exact; a set diff MSB means it went negative.
   assign shifted_s = {rem_i, bit_i};
   assign diff_s    = shifted_s - {1'b0, div_i};
   assign q_o       = ~diff_s[WIDTH];
   assign rem_o     = q_o ? diff_s[WIDTH-1:0] : shifted_s[WIDTH-1:0];

endmodule

// File: rtl/div_unit.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU. One quotient bit per
// cycle; divide-by-zero and signed overflow are resolved in a single cycle.
module div_unit
   import div_unit_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] res
);

   localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   op_e              op_q, op_d;
   logic             neg_q, neg_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   op_e              op_in_s;
   logic             sgn_a_s, sgn_b_s, ovf_s;
   logic [WIDTH-1:0] mag_a_s, mag_b_s;
   logic [WIDTH-1:0] step_rem_s, quo_next_s, res_mag_s, res_fix_s;
   logic             step_q_s;

   assign op_in_s = op_e'(op);
   assign sgn_a_s = is_signed_op(op_in_s) & src_a[WIDTH-1];
   assign sgn_b_s = is_signed_op(op_in_s) & src_b[WIDTH-1];
   assign mag_a_s = sgn_a_s ? (WIDTH'(0) - src_a) : src_a;
   assign mag_b_s = sgn_b_s ? (WIDTH'(0) - src_b) : src_b;
   assign ovf_s   = is_signed_op(op_in_s) && (src_a == MIN_NEG) && (src_b == ALL_ONES);

   // The dividend magnitude lives in quo_q and is shifted out MSB-first as quotient bits shift in.
   div_unit_step #(.WIDTH(WIDTH)) u_step (
      .rem_i (rem_q),
      .bit_i (quo_q[WIDTH-1]),
      .div_i (dvs_q),
      .rem_o (step_rem_s),
      .q_o   (step_q_s)
   );

   assign quo_next_s = {quo_q[WIDTH-2:0], step_q_s};
   assign res_mag_s  = is_rem_op(op_q) ? step_rem_s : quo_next_s;
   assign res_fix_s  = neg_q ? (WIDTH'(0) - res_mag_s) : res_mag_s;

   // Next-state and datapath control.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      neg_d   = neg_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvs_d   = dvs_q;
      res_d   = res_q;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      case (state_q)
         DIV_ST_IDLE: begin
            if (start) begin
               op_d  = op_in_s;
               cnt_d = CNT_W'(0);
               if (src_b == WIDTH'(0)) begin
                  done_d = 1'b1;
                  res_d  = is_rem_op(op_in_s) ? src_a : ALL_ONES;
               end else if (ovf_s) begin
                  done_d = 1'b1;
                  res_d  = is_rem_op(op_in_s) ? WIDTH'(0) : MIN_NEG;
               end else begin
                  state_d = DIV_ST_CALC;
                  busy_d  = 1'b1;
                  rem_d   = WIDTH'(0);
                  quo_d   = mag_a_s;
                  dvs_d   = mag_b_s;
                  neg_d   = is_rem_op(op_in_s) ? sgn_a_s : (sgn_a_s ^ sgn_b_s);
               end
            end else begin
               state_d = DIV_ST_IDLE;
            end
         end
         DIV_ST_CALC: begin
            rem_d  = step_rem_s;
            quo_d  = quo_next_s;
            cnt_d  = cnt_q + CNT_W'(1);
            busy_d = 1'b1;
            if (cnt_q == LAST_CNT) begin
               state_d = DIV_ST_IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               res_d   = res_fix_s;
            end else begin
               state_d = DIV_ST_CALC;
            end
         end
         default: begin
            state_d = DIV_ST_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= DIV_ST_IDLE;
         cnt_q   <= CNT_W'(0);
         op_q    <= DIV_DIV;
         neg_q   <= 1'b0;
         rem_q   <= WIDTH'(0);
         quo_q   <= WIDTH'(0);
         dvs_q   <= WIDTH'(0);
         res_q   <= WIDTH'(0);
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         neg_q   <= neg_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         dvs_q   <= dvs_d;
         res_q   <= res_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign res  = res_q;

endmodule
